// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives a valid/ready data bus, stalls while busy, returns extended load data.
// Optional response watchdog enabled by defining MEM_LSU_TIMEOUT_EN.
module mem_stage_lsu #(
  parameter logic [1:0] XLEN = 2'b10
`ifdef MEM_LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_mem_read_m,
  input  logic                           i_mem_write_m,
  input  logic [(1<<(XLEN+4))-1:0]       i_addr_m,
  input  logic [(1<<(XLEN+4))-1:0]       i_wdata_m,
  input  logic [2:0]                     i_f3_m,
  output logic                           o_stall_m,
  output logic                           o_req_valid,
  input  logic                           i_req_ready,
  output logic                           o_req_we,
  output logic [(1<<(XLEN+4))-1:0]       o_req_addr,
  output logic [(1<<(XLEN+4))-1:0]       o_req_wdata,
  output logic [(1<<(XLEN+4))/8-1:0]     o_req_strb,
  input  logic                           i_rsp_valid,
  input  logic [(1<<(XLEN+4))-1:0]       i_rsp_rdata,
  input  logic                           i_rsp_err,
  output logic [(1<<(XLEN+4))-1:0]       o_load_data_m,
  output logic                           o_done_m,
  output logic [3:0]                     o_exception_code_m
);

  localparam int DATA_W = 1 << (int'(XLEN) + 4);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DATA_W);
  localparam bit HAS_D  = (DATA_W >= 64);
  localparam logic [3:0] CODE_NONE = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [2:0]          f3_q, f3_d;
  logic [3:0]          code_q, code_d;
  logic [DATA_W-1:0]   load_q, load_d;

`ifdef MEM_LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc_s;
  assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`endif

  // Request decode on the incoming M-stage fields
  logic              access_s, illegal_s, misal_s, stall_s;
  logic [1:0]        size_s;
  logic [OFF_W-1:0]  off_s, align_mask_s;
  logic [3:0]        nbytes_s, bad_code_s, exc_s;
  logic [STRB_W-1:0] strb_s;

  assign access_s     = i_mem_read_m | i_mem_write_m;
  assign size_s       = i_f3_m[1:0];
  assign off_s        = i_addr_m[OFF_W-1:0];
  assign align_mask_s = OFF_W'((4'd1 << size_s) - 4'd1);
  assign misal_s      = |(off_s & align_mask_s);
  assign illegal_s    = !HAS_D && (size_s == 2'd3);
  assign nbytes_s     = 4'd1 << size_s;
  assign strb_s       = (~({STRB_W{1'b1}} << nbytes_s)) << off_s;
  assign bad_code_s   = illegal_s ? 4'd2 : (i_mem_write_m ? 4'd6 : 4'd4);

  // Load extraction works on the latched offset/funct3 of the outstanding access
  logic [DATA_W-1:0] shifted_s, mask_s, ext_s;
  logic [7:0]        nbits_s;
  logic [IDX_W-1:0]  sign_idx_s;
  logic              sign_s;

  assign shifted_s  = i_rsp_rdata >> {off_q, 3'b000};
  assign nbits_s    = 8'd8 << f3_q[1:0];
  assign mask_s     = ~({DATA_W{1'b1}} << nbits_s);
  assign sign_idx_s = IDX_W'(nbits_s - 8'd1);
  assign sign_s     = shifted_s[sign_idx_s] & ~f3_q[2];
  assign ext_s      = (shifted_s & mask_s) | ({DATA_W{sign_s}} & ~mask_s);

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    off_d   = off_q;
    f3_d    = f3_q;
    code_d  = code_q;
    load_d  = load_q;
    stall_s = 1'b0;
    exc_s   = CODE_NONE;
`ifdef MEM_LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (access_s && (illegal_s || misal_s)) begin
          exc_s = bad_code_s;
        end else if (access_s) begin
          stall_s = 1'b1;
          state_d = S_REQ;
          we_d    = i_mem_write_m;
          addr_d  = {i_addr_m[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
          wdata_d = i_wdata_m << {off_s, 3'b000};
          strb_d  = strb_s;
          off_d   = off_s;
          f3_d    = i_f3_m;
          code_d  = CODE_NONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        stall_s = 1'b1;
        if (i_req_ready) begin
          state_d = S_WAIT;
`ifdef MEM_LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        stall_s = 1'b1;
        if (i_rsp_valid) begin
          state_d = S_DONE;
          if (i_rsp_err) begin
            code_d = we_q ? 4'd7 : 4'd5;
          end else if (!we_q) begin
            load_d = ext_s;
          end else begin
            load_d = load_q;
          end
        end
`ifdef MEM_LSU_TIMEOUT_EN
        else if (cnt_inc_s == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d = S_DONE;
          code_d  = we_q ? 4'd7 : 4'd5;
        end else begin
          cnt_d = cnt_inc_s;
        end
`else
        else begin
          state_d = S_WAIT;
        end
`endif
      end
      S_DONE: begin
        exc_s   = code_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and access registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      off_q   <= '0;
      f3_q    <= 3'd0;
      code_q  <= CODE_NONE;
      load_q  <= '0;
`ifdef MEM_LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      code_q  <= code_d;
      load_q  <= load_d;
`ifdef MEM_LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign o_stall_m          = stall_s;
  assign o_req_valid        = (state_q == S_REQ);
  assign o_req_we           = we_q;
  assign o_req_addr         = addr_q;
  assign o_req_wdata        = wdata_q;
  assign o_req_strb         = strb_q;
  assign o_load_data_m      = load_q;
  assign o_done_m           = (state_q == S_DONE);
  assign o_exception_code_m = exc_s;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed accesses push expectations, a negedge monitor checks them.
module tb_mem_stage_lsu;

  localparam int TMO = 4;

  logic        i_clk, i_rst;
  logic        i_mem_read_m, i_mem_write_m;
  logic [63:0] i_addr_m, i_wdata_m;
  logic [2:0]  i_f3_m;
  logic        o_stall_m, o_req_valid, i_req_ready, o_req_we;
  logic [63:0] o_req_addr, o_req_wdata;
  logic [7:0]  o_req_strb;
  logic        i_rsp_valid, i_rsp_err;
  logic [63:0] i_rsp_rdata, o_load_data_m;
  logic        o_done_m;
  logic [3:0]  o_exception_code_m;

`ifdef MEM_LSU_TIMEOUT_EN
  mem_stage_lsu #(.XLEN(2'b10), .TIMEOUT_CYCLES(TMO)) dut (
`else
  mem_stage_lsu #(.XLEN(2'b10)) dut (
`endif
    .i_clk(i_clk), .i_rst(i_rst),
    .i_mem_read_m(i_mem_read_m), .i_mem_write_m(i_mem_write_m),
    .i_addr_m(i_addr_m), .i_wdata_m(i_wdata_m), .i_f3_m(i_f3_m),
    .o_stall_m(o_stall_m), .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
    .o_req_we(o_req_we), .o_req_addr(o_req_addr), .o_req_wdata(o_req_wdata),
    .o_req_strb(o_req_strb), .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
    .i_rsp_err(i_rsp_err), .o_load_data_m(o_load_data_m), .o_done_m(o_done_m),
    .o_exception_code_m(o_exception_code_m)
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
  } req_t;

  typedef struct {
    logic [3:0]  code;
    logic [63:0] data;
    int          stall;
    logic        done;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   stall_cnt = 0;
  req_t mq;
  rsp_t mr;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: checks bus requests every cycle and completion/exception events against the queues
  always @(negedge i_clk) begin
    if (i_rst) begin
      stall_cnt = 0;
    end else begin
      if (o_req_valid) begin
        if (req_q.size() == 0) begin
          chk("spurious_req", {63'd0, o_req_valid}, 64'd0);
        end else begin
          mq = req_q[0];
          chk("req_we",    {63'd0, o_req_we}, {63'd0, mq.we});
          chk("req_addr",  o_req_addr, mq.addr);
          chk("req_wdata", o_req_wdata, mq.wdata);
          chk("req_strb",  {56'd0, o_req_strb}, {56'd0, mq.strb});
          if (i_req_ready) void'(req_q.pop_front());
        end
      end
      if (o_stall_m) stall_cnt++;
      if (o_done_m || (o_exception_code_m != 4'b1111)) begin
        if (rsp_q.size() == 0) begin
          chk("spurious_event", {59'd0, o_done_m, o_exception_code_m}, {59'd0, 1'b0, 4'b1111});
        end else begin
          mr = rsp_q.pop_front();
          chk("done",      {63'd0, o_done_m}, {63'd0, mr.done});
          chk("exc_code",  {60'd0, o_exception_code_m}, {60'd0, mr.code});
          chk("load_data", o_load_data_m, mr.data);
          chk("stall_cycles", 64'(stall_cnt), 64'(mr.stall));
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic idle_inputs();
    i_mem_read_m  = 1'b0;
    i_mem_write_m = 1'b0;
    i_addr_m      = 64'd0;
    i_wdata_m     = 64'd0;
    i_f3_m        = 3'd0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Drive one M-stage access and service the bus; expectations are pushed up front
  task automatic access(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [2:0] f3, input int dly,
                        input logic [63:0] rdata, input logic err, input logic no_rsp,
                        input logic [3:0] code, input logic [63:0] data,
                        input logic [7:0] strb, input logic [63:0] bwdata, input logic misal);
    rsp_t r;
    req_t q;
    i_mem_read_m  = rd;
    i_mem_write_m = wr;
    i_addr_m      = addr;
    i_wdata_m     = wdata;
    i_f3_m        = f3;
    r.code  = code;
    r.data  = data;
    r.done  = !misal;
    r.stall = misal ? 0 : (no_rsp ? 2 + TMO : 3 + dly);
    rsp_q.push_back(r);
    if (misal) begin
      tick();
      idle_inputs();
    end else begin
      q.we    = wr;
      q.addr  = addr & ~64'h7;
      q.wdata = bwdata;
      q.strb  = strb;
      req_q.push_back(q);
      tick();
      repeat (dly) tick();
      i_req_ready = 1'b1;
      tick();
      i_req_ready = 1'b0;
      if (no_rsp) begin
        repeat (TMO) tick();
      end else begin
        i_rsp_valid = 1'b1;
        i_rsp_rdata = rdata;
        i_rsp_err   = err;
        tick();
        i_rsp_valid = 1'b0;
        i_rsp_err   = 1'b0;
      end
      idle_inputs();
      tick();
    end
  endtask

  initial begin
    i_rst       = 1'b1;
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b0;
    i_rsp_err   = 1'b0;
    i_rsp_rdata = 64'd0;
    idle_inputs();
    repeat (2) tick();
    chk("rst_req_valid", {63'd0, o_req_valid}, 64'd0);
    chk("rst_stall",     {63'd0, o_stall_m}, 64'd0);
    chk("rst_done",      {63'd0, o_done_m}, 64'd0);
    chk("rst_load",      o_load_data_m, 64'd0);
    chk("rst_code",      {60'd0, o_exception_code_m}, 64'hF);
    i_rst = 1'b0;
    tick();

    //     rd    wr    addr          wdata                  f3   dly rdata                  err   nors  code  data                   strb    bus wdata              misal
    access(1'b1, 1'b0, 64'h1003, 64'h0,                 3'd0, 0, 64'h0000_0000_80FF_0000, 1'b0, 1'b0, 4'hF, 64'hFFFF_FFFF_FFFF_FF80, 8'h08, 64'h0,                 1'b0);
    access(1'b0, 1'b1, 64'h1006, 64'hABCD,              3'd1, 0, 64'h0,                   1'b0, 1'b0, 4'hF, 64'hFFFF_FFFF_FFFF_FF80, 8'hC0, 64'hABCD_0000_0000_0000, 1'b0);
    access(1'b1, 1'b0, 64'h1002, 64'h0,                 3'd2, 0, 64'h0,                   1'b0, 1'b0, 4'd4, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0,                 1'b1);
    access(1'b1, 1'b0, 64'h2000, 64'h0,                 3'd5, 5, 64'h0000_0000_0000_8001, 1'b0, 1'b0, 4'hF, 64'h0000_0000_0000_8001, 8'h03, 64'h0,                 1'b0);
    access(1'b0, 1'b1, 64'h2008, 64'h1122334455667788,  3'd3, 0, 64'h0,                   1'b1, 1'b0, 4'd7, 64'h0000_0000_0000_8001, 8'hFF, 64'h1122334455667788,  1'b0);
    access(1'b1, 1'b0, 64'h3002, 64'h0,                 3'd1, 1, 64'h0000_0000_F00D_0000, 1'b0, 1'b0, 4'hF, 64'hFFFF_FFFF_FFFF_F00D, 8'h0C, 64'h0,                 1'b0);
    access(1'b1, 1'b0, 64'h3004, 64'h0,                 3'd2, 0, 64'h8765_4321_0000_0000, 1'b0, 1'b0, 4'hF, 64'hFFFF_FFFF_8765_4321, 8'hF0, 64'h0,                 1'b0);
    access(1'b1, 1'b0, 64'h3004, 64'h0,                 3'd6, 0, 64'h8765_4321_0000_0000, 1'b0, 1'b0, 4'hF, 64'h0000_0000_8765_4321, 8'hF0, 64'h0,                 1'b0);
    access(1'b1, 1'b0, 64'h3007, 64'h0,                 3'd4, 2, 64'hFE00_0000_0000_0000, 1'b0, 1'b0, 4'hF, 64'h0000_0000_0000_00FE, 8'h80, 64'h0,                 1'b0);
    access(1'b1, 1'b0, 64'h3000, 64'h0,                 3'd3, 0, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 4'hF, 64'hDEAD_BEEF_0123_4567, 8'hFF, 64'h0,                 1'b0);
    access(1'b1, 1'b0, 64'h3001, 64'h0,                 3'd0, 0, 64'h0000_0000_0000_5500, 1'b1, 1'b0, 4'd5, 64'hDEAD_BEEF_0123_4567, 8'h02, 64'h0,                 1'b0);
    access(1'b0, 1'b1, 64'h3005, 64'h5A,                3'd0, 0, 64'h0,                   1'b0, 1'b0, 4'hF, 64'hDEAD_BEEF_0123_4567, 8'h20, 64'h0000_5A00_0000_0000, 1'b0);
    access(1'b0, 1'b1, 64'h3006, 64'h0,                 3'd2, 0, 64'h0,                   1'b0, 1'b0, 4'd6, 64'hDEAD_BEEF_0123_4567, 8'h00, 64'h0,                 1'b1);
    access(1'b1, 1'b1, 64'h4000, 64'hCAFE_F00D,         3'd2, 0, 64'h0,                   1'b0, 1'b0, 4'hF, 64'hDEAD_BEEF_0123_4567, 8'h0F, 64'hCAFE_F00D,         1'b0);
    access(1'b1, 1'b1, 64'h4001, 64'h0,                 3'd1, 0, 64'h0,                   1'b0, 1'b0, 4'd6, 64'hDEAD_BEEF_0123_4567, 8'h00, 64'h0,                 1'b1);
    access(1'b1, 1'b0, 64'h4004, 64'h0,                 3'd3, 0, 64'h0,                   1'b0, 1'b0, 4'd4, 64'hDEAD_BEEF_0123_4567, 8'h00, 64'h0,                 1'b1);
`ifdef MEM_LSU_TIMEOUT_EN
    access(1'b1, 1'b0, 64'h5000, 64'h0,                 3'd3, 0, 64'h0,                   1'b0, 1'b1, 4'd5, 64'hDEAD_BEEF_0123_4567, 8'hFF, 64'h0,                 1'b0);
`endif

    // Reset while waiting for the response aborts the access; the late response is ignored
    begin
      req_t q;
      q.we = 1'b0; q.addr = 64'h3008; q.wdata = 64'h0; q.strb = 8'hFF;
      req_q.push_back(q);
      i_mem_read_m = 1'b1;
      i_addr_m     = 64'h3008;
      i_f3_m       = 3'd3;
      tick();
      i_req_ready = 1'b1;
      tick();
      i_req_ready = 1'b0;
      i_rst = 1'b1;
      idle_inputs();
      #1;
      chk("abort_req_valid", {63'd0, o_req_valid}, 64'd0);
      chk("abort_stall",     {63'd0, o_stall_m}, 64'd0);
      chk("abort_load",      o_load_data_m, 64'd0);
      tick();
      i_rst       = 1'b0;
      i_rsp_valid = 1'b1;
      i_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      i_rsp_valid = 1'b0;
      repeat (3) tick();
      chk("late_rsp_stall", {63'd0, o_stall_m}, 64'd0);
      chk("late_rsp_load",  o_load_data_m, 64'd0);
    end

    access(1'b1, 1'b0, 64'h6001, 64'h0, 3'd0, 0, 64'h0000_0000_0000_7F00, 1'b0, 1'b0, 4'hF, 64'h0000_0000_0000_007F, 8'h02, 64'h0, 1'b0);

    repeat (5) tick();
    chk("req_queue_drained", 64'(req_q.size()), 64'd0);
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
